arch_state_scoreboard: RTL

//  Sequential end-of-test checker comparing a DUT state array (register file or data memory)

---
 rtl/arch_state_scoreboard_pkg.sv | 39 +++
 rtl/arch_state_scoreboard_exp_table.sv | 64 ++++++
 rtl/arch_state_scoreboard.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_state_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// arch_state_scoreboard_pkg
// Shared types and constants for the end-of-test architectural state
// scoreboard: scan FSM states, the first-mismatch record, the reset polarity
// used by the codebase and the masked compare helper.
// ---------------------------------------------------------------------------
package arch_state_scoreboard_pkg;

  // Codebase reset: synchronous, active-high.
  localparam logic RST_ACTIVE = 1'b1;

  // Widths of the first-mismatch record. These match the widest checked
  // array (XLEN data, 32-entry register file index); narrower instances
  // zero-extend into the record.
  localparam int SCB_DATA_W = 32;
  localparam int SCB_IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } scb_state_t;

  typedef struct packed {
    logic [SCB_IDX_W-1:0]  idx;
    logic [SCB_DATA_W-1:0] got;
    logic [SCB_DATA_W-1:0] exp;
  } scb_err_t;

  // A bit only counts as different when its mask bit is set, so an
  // all-zero mask can never produce a mismatch.
  function automatic logic masked_mismatch(input logic [SCB_DATA_W-1:0] got,
                                           input logic [SCB_DATA_W-1:0] exp_val,
                                           input logic [SCB_DATA_W-1:0] mask);
    return (((got ^ exp_val) & mask) != {SCB_DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/arch_state_scoreboard_exp_table.sv
// ---------------------------------------------------------------------------
// scb_exp_table
// DEPTH x {data, mask} expected-value table. Synchronous write, combinational
// read. Reset loads data = 0 and mask = all-ones (every bit compared).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en               write strobe (already qualified by the caller)
//   wr_idx/wr_data/wr_mask  write index, expected value, compare mask
//   rd_idx              read index
//   rd_data/rd_mask     expected value and mask at rd_idx
// ---------------------------------------------------------------------------
module scb_exp_table
  import arch_state_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_mask
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];
  logic [DATA_W-1:0] mask_d [DEPTH];

  // Next-state of the table: one entry replaced on a write.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (wr_en) begin
      data_d[wr_idx] = wr_data;
      mask_d[wr_idx] = wr_mask;
    end else begin
      data_d = data_q;
      mask_d = mask_q;
    end
  end

  // Table storage with reset initialisation.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
        mask_q[i] <= {DATA_W{1'b1}};
      end
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign rd_data = data_q[rd_idx];
  assign rd_mask = mask_q[rd_idx];

endmodule

// File: rtl/arch_state_scoreboard.sv
// ---------------------------------------------------------------------------
// arch_state_scoreboard
// End-of-test checker: scans a DUT state array through a fixed-latency read
// port and compares every entry against a loadable expected table with
// per-bit masks. Reports pass/fail, the first mismatch and a saturating
// mismatch count.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exp_we/exp_idx/exp_data/exp_mask  expected-table write (IDLE only)
//   start                         begin a scan (accepted in IDLE only)
//   rd_en/rd_idx                  DUT read request, one index per cycle
//   rd_data                       DUT read data, RD_LAT cycles after rd_en
//   busy                          scan in progress (SCAN or DRAIN)
//   done                          one-cycle pulse, results valid
//   pass                          last completed scan had no mismatch
//   err_valid/err_idx/err_got/err_exp  first mismatch record
//   mismatch_cnt                  mismatches in last scan, saturating
// ---------------------------------------------------------------------------
module arch_state_scoreboard
  import arch_state_scoreboard_pkg::*;
#(
  parameter int DATA_W        = SCB_DATA_W,
  parameter int DEPTH         = 32,
  parameter int RD_LAT        = 1,
  parameter int CNT_W         = 8,
  parameter int STOP_ON_FIRST = 0,
  localparam int IDX_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] exp_mask,
  input  logic              start,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_valid,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_got,
  output logic [DATA_W-1:0] err_exp,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  scb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]  pipe_idx_q [RD_LAT];
  logic [IDX_W-1:0]  pipe_idx_d [RD_LAT];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  scb_err_t          err_q, err_d;
  logic              err_valid_q, err_valid_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;

  logic              idx_ok_s;
  logic              tbl_we_s;
  logic [IDX_W-1:0]  cmp_idx_s;
  logic [DATA_W-1:0] tbl_data_s;
  logic [DATA_W-1:0] tbl_mask_s;
  logic              mismatch_s;
  logic              older_vld_s;

  // Out-of-range table writes only exist when DEPTH is not a power of two.
  if ((1 << IDX_W) == DEPTH) begin : g_idx_full
    assign idx_ok_s = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_s = (exp_idx < IDX_W'(DEPTH));
  end

  assign tbl_we_s  = exp_we && (state_q == IDLE) && idx_ok_s;
  assign cmp_idx_s = pipe_idx_q[RD_LAT-1];

  scb_exp_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tbl_we_s),
    .wr_idx  (exp_idx),
    .wr_data (exp_data),
    .wr_mask (exp_mask),
    .rd_idx  (cmp_idx_s),
    .rd_data (tbl_data_s),
    .rd_mask (tbl_mask_s)
  );

  // The oldest pipeline stage lines up with rd_data for that request.
  assign mismatch_s = pipe_vld_q[RD_LAT-1] &&
                      masked_mismatch(SCB_DATA_W'(rd_data),
                                      SCB_DATA_W'(tbl_data_s),
                                      SCB_DATA_W'(tbl_mask_s));

  // Any request still travelling behind the oldest stage keeps DRAIN alive.
  always_comb begin
    older_vld_s = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      older_vld_s = older_vld_s | pipe_vld_q[i];
    end
  end

  // Scan FSM, read pipeline, comparator and result next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_valid_d = err_valid_q;
    pass_d      = pass_q;
    pipe_idx_d  = pipe_idx_q;

    // A request enters the pipeline every SCAN cycle.
    pipe_vld_d[0] = (state_q == SCAN);
    pipe_idx_d[0] = ptr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          ptr_d       = {IDX_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          err_d       = '0;
          err_valid_d = 1'b0;
          pass_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (ptr_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (!older_vld_s) begin
          state_d = FIN;
        end else begin
          state_d = DRAIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mismatch_s) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        err_d.idx   = SCB_IDX_W'(cmp_idx_s);
        err_d.got   = SCB_DATA_W'(rd_data);
        err_d.exp   = SCB_DATA_W'(tbl_data_s);
      end else begin
        err_d = err_q;
      end
      // Abort: stop issuing and drop every read still in flight.
      if (STOP_ON_FIRST != 0) begin
        state_d    = FIN;
        pipe_vld_d = {RD_LAT{1'b0}};
      end else begin
        pipe_vld_d = pipe_vld_d;
      end
    end else begin
      cnt_d = cnt_d;
    end

    // The verdict is taken from the count that includes the final compare.
    if (state_d == FIN) begin
      pass_d = (cnt_d == {CNT_W{1'b0}});
    end else begin
      pass_d = pass_d;
    end
  end

  assign done_d  = (state_d == FIN);
  assign busy_d  = (state_d == SCAN) || (state_d == DRAIN);
  assign rd_en_d = (state_d == SCAN);

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      pipe_vld_q  <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx_q[i] <= {IDX_W{1'b0}};
      end
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= '0;
      err_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_idx       = ptr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_valid    = err_valid_q;
  assign err_idx      = IDX_W'(err_q.idx);
  assign err_got      = DATA_W'(err_q.got);
  assign err_exp      = DATA_W'(err_q.exp);
  assign mismatch_cnt = cnt_q;

endmodule
